// File: rtl/fdc_host_if_if.sv
// CPU-side bus bundle for the floppy controller host interface.
// master: CPU bus decode side, drives strobes/selects/data, receives read data.
// slave : fdc_host_if, receives strobes/selects/data, drives read data.
interface fdc_host_if_if;
  logic [1:0] a_sel;
  logic [7:0] d_in;
  logic       wr_n;
  logic       rd_n;
  logic       iorq_n;
  logic       cs_n;
  logic       csff_n;
  logic [7:0] dout;
  logic       oe_n;

  modport master (
    output a_sel, d_in, wr_n, rd_n, iorq_n, cs_n, csff_n,
    input  dout, oe_n
  );

  modport slave (
    input  a_sel, d_in, wr_n, rd_n, iorq_n, cs_n, csff_n,
    output dout, oe_n
  );
endinterface

// File: rtl/fdc_host_if.sv
// Host interface for the floppy controller core: Beta-Disk system register
// (#FF), drive/side decode, motor-off hold timer, DRQ/INTRQ synchroniser and
// the status-read / data-access flags returned to the core.
// Optional macro FDC_SYSREG_READBACK_EN: when defined, a #FF read returns the
// low five system register bits in place of the constant ones.
module fdc_host_if #(
  parameter int                NUM_DRIVES  = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                TMO_W       = 16,
  parameter logic [TMO_W-1:0]  MOTOR_TMO   = 16'd50000
) (
  input  logic                  clk,
  input  logic                  reset,
  fdc_host_if_if.slave          bus,
  input  logic [7:0]            core_dout,
  input  logic                  core_drq,
  input  logic                  core_intrq,
  input  logic                  core_hld,
  output logic                  core_wr_en,
  output logic                  core_reset_n,
  output logic                  core_hrdy,
  output logic                  drq_r_dreg,
  output logic                  intrq_r_sreg,
  output logic                  fdc_side1,
  output logic                  fdc_motor,
  output logic [NUM_DRIVES-1:0] fdc_ds
);

  logic                   iow;
  logic                   iow_q;
  logic                   wr_pulse;
  logic [4:0]             sysreg;
  logic [4:0]             sysreg_nxt;
  logic [SYNC_STAGES-1:0] drq_sync;
  logic [SYNC_STAGES-1:0] intrq_sync;
  logic                   drq_s;
  logic                   intrq_s;
  logic                   sreg_set;
  logic                   dreg_set;
  logic [TMO_W-1:0]       motor_tmr;
  logic [7:0]             ff_rdata;
  logic [7:0]             dout_mux;
  logic                   unused_din;

  // Write to #FF: only the first cycle of a held strobe loads the register.
  assign iow        = ~bus.iorq_n & ~bus.wr_n & ~bus.csff_n;
  assign wr_pulse   = iow & ~iow_q;
  assign sysreg_nxt = wr_pulse ? bus.d_in[4:0] : sysreg;
  assign unused_din = ^bus.d_in[7:5];

  // System register and write-strobe edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sysreg <= '0;
      iow_q  <= 1'b0;
    end else begin
      sysreg <= sysreg_nxt;
      iow_q  <= iow;
    end
  end

  assign core_reset_n = sysreg[2];
  assign core_hrdy    = sysreg[3];
  assign fdc_side1    = ~sysreg[4];
  assign core_wr_en   = ~bus.cs_n & ~bus.wr_n & ~bus.iorq_n;

  // Synchronisers for the core's DRQ/INTRQ, which come from another clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      drq_sync   <= '0;
      intrq_sync <= '0;
    end else begin
      drq_sync   <= {drq_sync[SYNC_STAGES-2:0], core_drq};
      intrq_sync <= {intrq_sync[SYNC_STAGES-2:0], core_intrq};
    end
  end

  assign drq_s   = drq_sync[SYNC_STAGES-1];
  assign intrq_s = intrq_sync[SYNC_STAGES-1];

  assign sreg_set = ~bus.iorq_n & ~bus.rd_n & ~bus.cs_n & (bus.a_sel == 2'b00);
  assign dreg_set = ~bus.iorq_n & (~bus.rd_n | ~bus.wr_n) & ~bus.cs_n & (bus.a_sel == 2'b11);

  // Access flags: a set only takes effect while the flag is clear; once set, the
  // flag follows its synchronised request down. Checking the incoming sysreg
  // value clears the flags on the same edge a write drops the core reset bit.
  always_ff @(posedge clk) begin
    if (reset || !sysreg_nxt[2]) begin
      intrq_r_sreg <= 1'b0;
      drq_r_dreg   <= 1'b0;
    end else begin
      intrq_r_sreg <= intrq_r_sreg ? intrq_s : sreg_set;
      drq_r_dreg   <= drq_r_dreg   ? drq_s   : dreg_set;
    end
  end

  // Motor hold timer: reloaded while head-load is requested, then counts to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      motor_tmr <= '0;
    end else if (core_hld) begin
      motor_tmr <= MOTOR_TMO;
    end else if (motor_tmr != '0) begin
      motor_tmr <= motor_tmr - TMO_W'(1);
    end
  end

  assign fdc_motor = core_hld | (motor_tmr != '0);

  // Drive select decode; select codes beyond the fitted drives leave all off.
  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_ds
    assign fdc_ds[i] = fdc_motor & (sysreg[1:0] == 2'(i));
  end

`ifdef FDC_SYSREG_READBACK_EN
  assign ff_rdata = {intrq_s, drq_s, 1'b1, sysreg};
`else
  assign ff_rdata = {intrq_s, drq_s, 6'h3F};
`endif

  // CPU read mux: controller registers take precedence over #FF.
  always_comb begin
    dout_mux = 8'hFF;
    if (!bus.rd_n && !bus.cs_n) begin
      dout_mux = core_dout;
    end else if (!bus.rd_n && !bus.csff_n) begin
      dout_mux = ff_rdata;
    end
  end

  assign bus.dout = dout_mux;
  assign bus.oe_n = ~(~bus.rd_n & (~bus.cs_n | ~bus.csff_n));

endmodule
